// File: rtl/clk_div_pkg.sv
// Shared constants and clamp helpers for the divided-clock bank.
package clk_div_pkg;

   localparam int DEF_DIV_W       = 16;
   localparam int DEF_DIV_RATIO   = 8;
   localparam int DEF_LOCK_CYCLES = 1024;
   localparam int FN_W            = 32;

   function automatic logic [FN_W-1:0] clamp_div(input logic [FN_W-1:0] n);
      return (n < FN_W'(2)) ? FN_W'(2) : n;
   endfunction

   // n must already be clamped; keeps duty strictly between 0% and 100%
   function automatic logic [FN_W-1:0] clamp_hi(input logic [FN_W-1:0] n,
                                                input logic [FN_W-1:0] h);
      if (h == '0)
         return n >> 1;
      else if (h >= n)
         return n - FN_W'(1);
      else
         return h;
   endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, pending/active config, apply at wrap or sync,
// registered divided clock and end-of-period strobe.
module clk_div_ch
   import clk_div_pkg::*;
#(
   parameter int DIV_W   = DEF_DIV_W,
   parameter int DEF_DIV = DEF_DIV_RATIO
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             wr,
   input  logic [DIV_W-1:0] wr_div,
   input  logic [DIV_W-1:0] wr_hi,
   input  logic             sync,
   output logic             div_clk,
   output logic             div_stb,
   output logic             pend
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] act_div;
   logic [DIV_W-1:0] act_hi;
   logic [DIV_W-1:0] pend_div;
   logic [DIV_W-1:0] pend_hi;
   logic [DIV_W-1:0] src_div;
   logic [DIV_W-1:0] src_hi;
   logic [DIV_W-1:0] new_div;
   logic [DIV_W-1:0] new_hi;
   logic             wrap;
   logic             apply;

   always_comb begin
      wrap    = (cnt == act_div - DIV_W'(1));
      // a write coinciding with sync bypasses the pending regs so the same sync applies it
      src_div = (sync && wr) ? wr_div : pend_div;
      src_hi  = (sync && wr) ? wr_hi  : pend_hi;
      new_div = DIV_W'(clamp_div(FN_W'(src_div)));
      new_hi  = DIV_W'(clamp_hi(FN_W'(new_div), FN_W'(src_hi)));
      apply   = run && (sync ? (pend || wr) : (wrap && pend));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         act_div  <= DIV_W'(DEF_DIV);
         act_hi   <= DIV_W'(DEF_DIV / 2);
         pend_div <= DIV_W'(DEF_DIV);
         pend_hi  <= DIV_W'(DEF_DIV / 2);
         pend     <= 1'b0;
         div_clk  <= 1'b0;
         div_stb  <= 1'b0;
      end else begin
         if (wr) begin
            pend_div <= wr_div;
            pend_hi  <= wr_hi;
         end

         if (apply) begin
            act_div <= new_div;
            act_hi  <= new_hi;
         end

         if (run && sync)
            pend <= 1'b0;
         else if (wr)
            pend <= 1'b1;
         else if (apply)
            pend <= 1'b0;

         // sync forces one low cycle so every channel's first rising edge lines up
         if (!run || sync) begin
            cnt     <= '0;
            div_clk <= 1'b0;
            div_stb <= 1'b0;
         end else begin
            div_clk <= (cnt < act_hi);
            div_stb <= wrap;
            cnt     <= wrap ? '0 : cnt + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of programmable clock dividers behind a qualified PLL lock.
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int DIV_W       = DEF_DIV_W,
   parameter int DEF_DIV     = DEF_DIV_RATIO,
   parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pll_locked,
   input  logic              cfg_wr,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic [DIV_W-1:0]  cfg_hi,
   input  logic              cfg_sync,
   output logic              ready,
   output logic [NUM_CH-1:0] div_clk,
   output logic [NUM_CH-1:0] div_stb,
   output logic [NUM_CH-1:0] cfg_pend
);

   localparam int LC_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

   logic              lock_s1;
   logic              lock_s2;
   logic [LC_W-1:0]   lock_cnt;
   logic              lock_full;
   logic [NUM_CH-1:0] wr_vec;

   assign lock_full = (lock_cnt == LC_W'(LOCK_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_s1  <= 1'b0;
         lock_s2  <= 1'b0;
         lock_cnt <= '0;
         ready    <= 1'b0;
      end else begin
         lock_s1 <= pll_locked;
         lock_s2 <= lock_s1;
         if (!lock_s2)
            lock_cnt <= '0;
         else if (!lock_full)
            lock_cnt <= lock_cnt + LC_W'(1);
         ready <= lock_s2 && lock_full;
      end
   end

   // out-of-range channel numbers decode to no write at all
   always_comb begin
      wr_vec = '0;
      for (int i = 0; i < NUM_CH; i++)
         wr_vec[i] = cfg_wr && (cfg_ch == CH_W'(i));
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clk_div_ch #(
         .DIV_W   (DIV_W),
         .DEF_DIV (DEF_DIV)
      ) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .run     (ready),
         .wr      (wr_vec[g]),
         .wr_div  (cfg_div),
         .wr_hi   (cfg_hi),
         .sync    (cfg_sync),
         .div_clk (div_clk[g]),
         .div_stb (div_stb[g]),
         .pend    (cfg_pend[g])
      );
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed plus random bench for clk_div_bank against a time-based reference model.
module tb_clk_div_bank;

   localparam int NUM_CH      = 3;
   localparam int DIV_W       = 16;
   localparam int DEF_DIV     = 8;
   localparam int LOCK_CYCLES = 16;
   localparam int CH_W        = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              pll_locked = 1'b0;
   logic              cfg_wr = 1'b0;
   logic [CH_W-1:0]   cfg_ch = '0;
   logic [DIV_W-1:0]  cfg_div = '0;
   logic [DIV_W-1:0]  cfg_hi = '0;
   logic              cfg_sync = 1'b0;
   logic              ready;
   logic [NUM_CH-1:0] div_clk;
   logic [NUM_CH-1:0] div_stb;
   logic [NUM_CH-1:0] cfg_pend;

   int total = 0;
   int bad = 0;

   clk_div_bank #(
      .NUM_CH      (NUM_CH),
      .DIV_W       (DIV_W),
      .DEF_DIV     (DEF_DIV),
      .LOCK_CYCLES (LOCK_CYCLES)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pll_locked (pll_locked),
      .cfg_wr     (cfg_wr),
      .cfg_ch     (cfg_ch),
      .cfg_div    (cfg_div),
      .cfg_hi     (cfg_hi),
      .cfg_sync   (cfg_sync),
      .ready      (ready),
      .div_clk    (div_clk),
      .div_stb    (div_stb),
      .cfg_pend   (cfg_pend)
   );

   always #5 clk = ~clk;

   // reference model: lock history lengths, per-channel period start time and config
   int cyc = 0;
   int run_q0 = 0, run_d1 = 0, run_d2 = 0;
   bit m_ready = 1'b0;
   int m_start[NUM_CH];
   int m_n[NUM_CH];
   int m_h[NUM_CH];
   int p_n[NUM_CH];
   int p_h[NUM_CH];
   bit m_pend[NUM_CH];
   logic [NUM_CH-1:0] e_clk = '0, e_stb = '0, e_pend = '0;

   task automatic apply_cfg(input int ch, input int n, input int h);
      m_n[ch] = (n < 2) ? 2 : n;
      if (h == 0)             m_h[ch] = m_n[ch] / 2;
      else if (h >= m_n[ch])  m_h[ch] = m_n[ch] - 1;
      else                    m_h[ch] = h;
   endtask

   task automatic model_edge();
      int ph;
      bit hit, at_end;
      cyc++;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         hit = cfg_wr && (int'(cfg_ch) == ch);
         at_end = 1'b0;
         if (!m_ready) begin
            e_clk[ch] = 1'b0;
            e_stb[ch] = 1'b0;
            m_start[ch] = cyc;
         end else if (cfg_sync) begin
            e_clk[ch] = 1'b0;
            e_stb[ch] = 1'b0;
            if (hit) apply_cfg(ch, int'(cfg_div), int'(cfg_hi));
            else if (m_pend[ch]) apply_cfg(ch, p_n[ch], p_h[ch]);
            m_start[ch] = cyc;
         end else begin
            ph = (cyc - 1 - m_start[ch]) % m_n[ch];
            e_clk[ch] = (ph < m_h[ch]);
            at_end = (ph == m_n[ch] - 1);
            e_stb[ch] = at_end;
            if (at_end) begin
               if (m_pend[ch]) apply_cfg(ch, p_n[ch], p_h[ch]);
               m_start[ch] = cyc;
            end
         end
         if (m_ready && cfg_sync) m_pend[ch] = 1'b0;
         else if (hit)            m_pend[ch] = 1'b1;
         else if (at_end)         m_pend[ch] = 1'b0;
         if (hit) begin
            p_n[ch] = int'(cfg_div);
            p_h[ch] = int'(cfg_hi);
         end
         e_pend[ch] = m_pend[ch];
      end
      run_d2 = run_d1;
      run_d1 = run_q0;
      run_q0 = pll_locked ? run_q0 + 1 : 0;
      m_ready = (run_d2 >= LOCK_CYCLES);
   endtask

   task automatic check_all();
      total++;
      assert (ready === m_ready) else begin
         bad++; $error("FAIL ready cyc=%0d got=%b exp=%b", cyc, ready, m_ready);
      end
      total++;
      assert (div_clk === e_clk) else begin
         bad++; $error("FAIL div_clk cyc=%0d got=%b exp=%b", cyc, div_clk, e_clk);
      end
      total++;
      assert (div_stb === e_stb) else begin
         bad++; $error("FAIL div_stb cyc=%0d got=%b exp=%b", cyc, div_stb, e_stb);
      end
      total++;
      assert (cfg_pend === e_pend) else begin
         bad++; $error("FAIL cfg_pend cyc=%0d got=%b exp=%b", cyc, cfg_pend, e_pend);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic drive(input bit wr, input int ch, input int dv, input int hi, input bit sy);
      cfg_wr   = wr;
      cfg_ch   = CH_W'(ch);
      cfg_div  = DIV_W'(dv);
      cfg_hi   = DIV_W'(hi);
      cfg_sync = sy;
      tick();
      cfg_wr   = 1'b0;
      cfg_sync = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int k;
      int r;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         m_start[ch] = 0;
         m_n[ch] = DEF_DIV;
         m_h[ch] = DEF_DIV / 2;
         p_n[ch] = DEF_DIV;
         p_h[ch] = DEF_DIV / 2;
         m_pend[ch] = 1'b0;
      end

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;

      // lock qualification with a one-cycle dropout part way through the count
      pll_locked = 1'b1;
      idle(12);
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      k = 0;
      while (ready !== 1'b1 && k < 100) begin
         tick();
         k++;
      end
      total++;
      assert (k === LOCK_CYCLES + 2) else begin
         bad++; $error("FAIL lock_latency got=%0d exp=%0d", k, LOCK_CYCLES + 2);
      end

      // defaults, then a mid-period ratio change on ch1
      idle(21);
      drive(1, 1, 5, 0, 0);
      idle(20);

      // clamps and an out-of-range channel write
      drive(1, 2, 1, 9, 0);
      idle(3);
      drive(1, 0, 6, 6, 0);
      idle(2);
      drive(1, 3, 3, 1, 0);
      idle(30);

      // sync after programming N=4 and N=6 at unrelated phases
      drive(1, 0, 4, 0, 0);
      idle(3);
      drive(1, 1, 6, 0, 0);
      idle($urandom_range(1, 7));
      drive(0, 0, 0, 0, 1);
      idle(30);
      drive(1, 2, 3, 2, 1);
      idle(15);

      // lock loss mid-period and recovery
      pll_locked = 1'b0;
      idle(8);
      pll_locked = 1'b1;
      idle(40);

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         r = $urandom_range(0, 99);
         if (r < 8)
            drive(1, $urandom_range(0, 3), $urandom_range(0, 12), $urandom_range(0, 14), 0);
         else if (r < 10)
            drive($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 12),
                  $urandom_range(0, 14), 1);
         else if (r == 10) begin
            pll_locked = 1'b0;
            idle($urandom_range(1, 4));
            pll_locked = 1'b1;
         end else
            tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
